// File: rtl/fetch_pkg.sv
// Shared constants and the instruction-buffer entry layout for the fetch stage.
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam int          PC_STEP    = 4;
  localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic                  filled;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] insn;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer: entries are allocated at request time, filled by
// responses in order, and popped at the head. Pointers carry a wrap bit.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [FETCH_XLEN-1:0] alloc_pc_i,
  input  logic                  fill_i,
  input  logic [FETCH_XLEN-1:0] fill_insn_i,
  input  logic                  pop_i,
  output logic                  head_rdy_o,
  output logic [FETCH_XLEN-1:0] head_pc_o,
  output logic [FETCH_XLEN-1:0] head_insn_o,
  output logic [PW-1:0]         count_o,
  output logic [PW-1:0]         inflight_o
);

  localparam int AW = PW - 1;

  buf_entry_t    ent_q [DEPTH];
  logic [PW-1:0] head_q, fill_q, tail_q;
  logic [AW-1:0] hidx, fidx, tidx;

  assign hidx = head_q[AW-1:0];
  assign fidx = fill_q[AW-1:0];
  assign tidx = tail_q[AW-1:0];

  // A full buffer may pop and allocate the same slot in one cycle; the
  // allocation is written last so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid  <= 1'b0;
        ent_q[i].filled <= 1'b0;
      end
    end else begin
      if (pop_i) begin
        ent_q[hidx].valid  <= 1'b0;
        ent_q[hidx].filled <= 1'b0;
        head_q             <= head_q + PW'(1);
      end
      if (fill_i) begin
        ent_q[fidx].filled <= 1'b1;
        ent_q[fidx].insn   <= fill_insn_i;
        fill_q             <= fill_q + PW'(1);
      end
      if (alloc_i) begin
        ent_q[tidx].valid  <= 1'b1;
        ent_q[tidx].filled <= 1'b0;
        ent_q[tidx].pc     <= alloc_pc_i;
        tail_q             <= tail_q + PW'(1);
      end
    end
  end

  assign head_rdy_o  = ent_q[hidx].valid & ent_q[hidx].filled;
  assign head_pc_o   = ent_q[hidx].pc;
  assign head_insn_o = ent_q[hidx].insn;
  assign count_o     = tail_q - head_q;
  assign inflight_o  = tail_q - fill_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, credit-limited memory requests, redirect flush
// with discard of stale responses. XLEN must match FETCH_XLEN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] current_instruction,
  output logic [XLEN-1:0] current_pc
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   count, inflight, occ_after;
  logic            pop, hs, drop_pending, rsp_take;

  fetch_buffer #(.DEPTH(BUF_DEPTH), .PW(PW)) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (redirect_valid),
    .alloc_i     (hs),
    .alloc_pc_i  (fetch_pc_q),
    .fill_i      (rsp_take),
    .fill_insn_i (imem_rsp_data),
    .pop_i       (pop),
    .head_rdy_o  (instr_valid),
    .head_pc_o   (current_pc),
    .head_insn_o (current_instruction),
    .count_o     (count),
    .inflight_o  (inflight)
  );

  assign pop          = instr_valid && !stall;
  assign drop_pending = (drop_q != '0);
  // The slot freed by this cycle's consume counts as a credit, which is what
  // lets a two-entry buffer sustain one instruction per cycle.
  assign occ_after    = count - PW'(pop);
  assign imem_req_valid = run_q && (occ_after < PW'(BUF_DEPTH)) &&
                          !redirect_valid && !drop_pending;
  assign imem_req_addr  = fetch_pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && !redirect_valid && !drop_pending;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = drop_q + inflight - PW'(imem_rsp_valid);
    end else begin
      if (hs)                             fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && drop_pending) drop_d     = drop_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

endmodule
